forward_hazard_unit: RTL

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

---
 rtl/forward_hazard_unit_pkg.sv | 16 +
 rtl/forward_hazard_unit_fwd_port_sel.sv | 33 +++
 rtl/forward_hazard_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/forward_hazard_unit_pkg.sv
// Shared encodings for the forwarding/hazard unit: operand select codes
// and the state type of the multi-cycle (MDU) tracking FSM.
package forward_hazard_unit_pkg;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_WB  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [1:0] SEL_MDU = 2'd3;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/forward_hazard_unit_fwd_port_sel.sv
// Priority compare for one source operand port: picks where the operand
// value comes from (MEM beats WB beats the MDU result, else register file).
module fwd_port_sel
  import forward_hazard_unit_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              port_used,
  input  logic [ADDR_W-1:0] rd_mem,
  input  logic              regwrite_mem,
  input  logic [ADDR_W-1:0] rd_wb,
  input  logic              regwrite_wb,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_rd,
  output logic [1:0]        sel
);

  // Unused ports and r0 never forward; otherwise the youngest producer wins.
  always_comb begin
    sel = SEL_RF;
    if (port_used && (addr != '0)) begin
      if (regwrite_mem && (rd_mem == addr)) begin
        sel = SEL_MEM;
      end else if (regwrite_wb && (rd_wb == addr)) begin
        sel = SEL_WB;
      end else if (mdu_valid && (mdu_rd == addr)) begin
        sel = SEL_MDU;
      end
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding and hazard unit: operand select generation for the ID and EX
// stages, stall detection, MDU latency tracking and a stall-cycle counter.
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int N_RD    = 2,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_RD*ADDR_W-1:0] rs_id,
  input  logic [N_RD-1:0]        use_id,
  input  logic [ADDR_W-1:0]      rd_id,
  input  logic                   regwrite_id,
  input  logic                   branch_id,
  input  logic                   mdu_op_id,
  input  logic [N_RD*ADDR_W-1:0] rs_ex,
  input  logic [N_RD-1:0]        use_ex,
  input  logic [ADDR_W-1:0]      rd_ex,
  input  logic                   regwrite_ex,
  input  logic                   memread_ex,
  input  logic                   mdu_start_ex,
  input  logic [ADDR_W-1:0]      rd_mem,
  input  logic                   regwrite_mem,
  input  logic                   memread_mem,
  input  logic [ADDR_W-1:0]      rd_wb,
  input  logic                   regwrite_wb,
  input  logic                   perf_clr,
  output logic [2*N_RD-1:0]      fwd_ex_sel,
  output logic [2*N_RD-1:0]      fwd_id_sel,
  output logic                   stall_id,
  output logic                   mdu_wb_valid,
  output logic                   mdu_busy,
  output logic                   mdu_err,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int              LAT_W    = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MDU_LAT - 2);

  mdu_state_t        state, state_nx;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_nx;
  logic [ADDR_W-1:0] mdu_rd, mdu_rd_nx;
  logic              err_nx;

  // EX ports occupy the low half, ID ports the high half of the select bank.
  logic [2*N_RD*ADDR_W-1:0] all_addr;
  logic [2*N_RD-1:0]        all_used;
  logic [4*N_RD-1:0]        all_sel;

  assign all_addr     = {rs_id, rs_ex};
  assign all_used     = {use_id, use_ex};
  assign fwd_ex_sel   = all_sel[2*N_RD-1:0];
  assign fwd_id_sel   = all_sel[4*N_RD-1:2*N_RD];
  assign mdu_wb_valid = (state == MDU_DONE);
  assign mdu_busy     = (state == MDU_BUSY);

  for (genvar g = 0; g < 2*N_RD; g++) begin : g_port
    fwd_port_sel #(.ADDR_W(ADDR_W)) u_sel (
      .addr         (all_addr[g*ADDR_W +: ADDR_W]),
      .port_used    (all_used[g]),
      .rd_mem       (rd_mem),
      .regwrite_mem (regwrite_mem),
      .rd_wb        (rd_wb),
      .regwrite_wb  (regwrite_wb),
      .mdu_valid    (mdu_wb_valid),
      .mdu_rd       (mdu_rd),
      .sel          (all_sel[2*g +: 2])
    );
  end

  // Stall when an ID source cannot be forwarded in time, or the MDU blocks ID.
  always_comb begin
    stall_id = 1'b0;
    for (int i = 0; i < N_RD; i++) begin
      if (use_id[i]) begin
        if (memread_ex && regwrite_ex && (rd_ex != '0) &&
            (rd_ex == rs_id[i*ADDR_W +: ADDR_W])) begin
          stall_id = 1'b1;
        end
        if (branch_id && regwrite_ex && (rd_ex != '0) &&
            (rd_ex == rs_id[i*ADDR_W +: ADDR_W])) begin
          stall_id = 1'b1;
        end
        if (branch_id && memread_mem && (rd_mem != '0) &&
            (rd_mem == rs_id[i*ADDR_W +: ADDR_W])) begin
          stall_id = 1'b1;
        end
        if (mdu_busy && (mdu_rd == rs_id[i*ADDR_W +: ADDR_W])) begin
          stall_id = 1'b1;
        end
      end
    end
    if (mdu_busy && ((regwrite_id && (rd_id == mdu_rd)) || mdu_op_id)) begin
      stall_id = 1'b1;
    end
  end

  // MDU tracking: issue loads the down-counter, DONE lasts a single cycle.
  always_comb begin
    state_nx   = state;
    lat_cnt_nx = lat_cnt;
    mdu_rd_nx  = mdu_rd;
    err_nx     = mdu_err;
    case (state)
      MDU_IDLE: begin
        if (mdu_start_ex && (rd_ex != '0)) begin
          state_nx   = MDU_BUSY;
          mdu_rd_nx  = rd_ex;
          lat_cnt_nx = LAT_LOAD;
        end
      end
      MDU_BUSY: begin
        if (mdu_start_ex) begin
          err_nx = 1'b1;
        end
        if (lat_cnt == '0) begin
          state_nx = MDU_DONE;
        end else begin
          lat_cnt_nx = lat_cnt - 1'b1;
        end
      end
      MDU_DONE: begin
        if (mdu_start_ex && (rd_ex != '0)) begin
          state_nx   = MDU_BUSY;
          mdu_rd_nx  = rd_ex;
          lat_cnt_nx = LAT_LOAD;
        end else begin
          state_nx = MDU_IDLE;
        end
      end
      default: state_nx = MDU_IDLE;
    endcase
  end

  // MDU state register; reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MDU_IDLE;
      lat_cnt <= '0;
      mdu_rd  <= '0;
      mdu_err <= 1'b0;
    end else begin
      state   <= state_nx;
      lat_cnt <= lat_cnt_nx;
      mdu_rd  <= mdu_rd_nx;
      mdu_err <= err_nx;
    end
  end

  // Saturating stall counter; a clear wins over a same-cycle stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt <= '0;
    end else if (stall_id && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
